// File: rtl/muldiv_if.sv
// Issue/writeback bundle for the iterative multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on sign-stripped operands with sign fix-up in FINISH.
module muldiv_unit (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e      state;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        neg_a_q, neg_b_q, special_q;
  logic [31:0] a_q, b_q, quo_q, rem_q;
  logic [63:0] prod_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

  // Acceptance-side decode of operand signedness and special divide cases.
  logic        sgn_a, sgn_b, div_zero, div_ovf, special;
  logic [31:0] abs_a, abs_b, special_val;

  always_comb begin
    sgn_a    = bus.op_a[31] & (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    sgn_b    = bus.op_b[31] & (bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    abs_a    = sgn_a ? -bus.op_a : bus.op_a;
    abs_b    = sgn_b ? -bus.op_b : bus.op_b;
    div_zero = bus.funct3[2] && (bus.op_b == 32'd0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == 32'h8000_0000) &&
               (bus.op_b == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_val = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
    end else begin
      special_val = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of each datapath.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    div_shift = {rem_q, quo_q[31]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[31:0] - b_q;
  end

  // Sign fix-up and result selection for the FINISH edge.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fin_result;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    rem_fix  = neg_a_q ? -rem_q : rem_q;
    case (f3_q)
      3'b000:                 fin_result = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fin_result = prod_fix[63:32];
      3'b100, 3'b101:         fin_result = quo_fix;
      default:                fin_result = rem_fix;
    endcase
    if (special_q) begin
      fin_result = quo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      f3_q      <= 3'd0;
      rd_q      <= 5'd0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      prod_q    <= 64'd0;
      cnt_q     <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      rd_out_q  <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        StIdle: begin
          if (bus.start) begin
            f3_q      <= bus.funct3;
            rd_q      <= bus.rd_in;
            neg_a_q   <= sgn_a;
            neg_b_q   <= sgn_b;
            special_q <= special;
            a_q       <= abs_a;
            b_q       <= abs_b;
            // quo_q doubles as dividend shifter and as holder of the special result.
            quo_q     <= special ? special_val : abs_a;
            rem_q     <= 32'd0;
            prod_q    <= {32'd0, abs_b};
            cnt_q     <= 6'd0;
            busy_q    <= 1'b1;
            state     <= special ? StFinish : StCalc;
          end
        end
        StCalc: begin
          if (f3_q[2]) begin
            rem_q <= div_ge ? div_diff : div_shift[31:0];
            quo_q <= {quo_q[30:0], div_ge};
          end else begin
            prod_q <= {mul_sum, prod_q[31:1]};
          end
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state <= StFinish;
          end
        end
        StFinish: begin
          result_q <= fin_result;
          rd_out_q <= rd_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
